// File: rtl/athena_vbus_pkg.sv
// ---------------------------------------------------------------------------
// athena_vbus_pkg
// Shared types and constants for the video-RAM bus arbiter.
//   vbus_state_t  : access sequencer states (IDLE, SETUP, STROBE, HOLD)
//   CPU_PHASE     : the one phase out of four that belongs to the CPUs
//   vbus_req_t    : one captured CPU request (we, addr, wdata)
//   nextPhase()   : phase counter step with optional force-to-zero
// ---------------------------------------------------------------------------
package athena_vbus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } vbus_state_t;

    localparam logic [1:0] CPU_PHASE = 2'd3;

    // The request bundle carries the widest address the arbiter accepts.
    // Narrower address buses are zero-extended into it.
    localparam int VBUS_ADDR_MAX = 16;

    typedef struct packed {
        logic                     we;
        logic [VBUS_ADDR_MAX-1:0] addr;
        logic [7:0]               wdata;
    } vbus_req_t;

    // Phase advances modulo 4; a pending line sync restarts the line at 0.
    function automatic logic [1:0] nextPhase(input logic [1:0] phase,
                                             input logic       forceZero);
        return forceZero ? 2'd0 : phase + 2'd1;
    endfunction

endpackage

// File: rtl/athena_rr_arb2.sv
// ---------------------------------------------------------------------------
// athena_rr_arb2
// Two-way round-robin arbiter. A grant is produced only while arb_en is high;
// when both requesters are active the one that did not win last time wins.
//   clk, reset  : clock, synchronous active-high reset
//   req[1:0]    : request vector, bit 0 = A, bit 1 = B
//   arb_en      : arbitration strobe, grants are issued only in this cycle
//   gnt_onehot  : one-hot grant (all zero when nothing is granted)
//   gnt_id      : index of the granted requester (0 = A, 1 = B)
// ---------------------------------------------------------------------------
module athena_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       arb_en,
    output logic [1:0] gnt_onehot,
    output logic       gnt_id
);

    logic lastGrant_q;

    // Pick a winner. On a tie the requester that was not served last wins,
    // which alternates service when both keep requesting.
    always_comb begin
        gnt_onehot = 2'b00;
        gnt_id     = 1'b0;
        if (arb_en) begin
            case (req)
                2'b01: begin
                    gnt_onehot = 2'b01;
                    gnt_id     = 1'b0;
                end
                2'b10: begin
                    gnt_onehot = 2'b10;
                    gnt_id     = 1'b1;
                end
                2'b11: begin
                    gnt_id     = ~lastGrant_q;
                    gnt_onehot = lastGrant_q ? 2'b01 : 2'b10;
                end
                default: begin
                    gnt_onehot = 2'b00;
                    gnt_id     = 1'b0;
                end
            endcase
        end
    end

    // Remember who was served. Resetting to B means A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q <= 1'b1;
        end else if (|gnt_onehot) begin
            lastGrant_q <= gnt_id;
        end
    end

endmodule

// File: rtl/athena_vbus_arbiter.sv
// ---------------------------------------------------------------------------
// athena_vbus_arbiter
// Shares the video-RAM bus between video fetch (phases 0-2) and two CPU
// requesters (phase 3). One CPU read or write is sequenced per CPU window
// with a request/acknowledge handshake.
//   clk, reset           : clock, synchronous active-high reset
//   phase_cen            : one-clk pulse advancing the 4-phase counter
//   line_sync            : forces phase 0 at the next phase_cen
//   pause_cpu            : blocks new grants (in-flight access completes)
//   a_* / b_*            : CPU requesters (req level, we, addr, wdata in;
//                          ack one-clk pulse, rdata out)
//   VD_in                : read data from the RAM
//   VA, VD_out           : shared address and write data buses
//   V_C                  : bus owner, 0 = video, 1 = CPU
//   VWE_n, VOE_n         : active-low write / read strobes
//   phase                : current phase
//   grant_id             : served CPU (0 = A, 1 = B), valid while V_C = 1
// All bus outputs come straight from flops so the strobes are glitch-free.
// ---------------------------------------------------------------------------
module athena_vbus_arbiter
    import athena_vbus_pkg::*;
#(
    parameter int AW         = 13,
    parameter int STROBE_LEN = 4,
    parameter int CEN_PERIOD = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          phase_cen,
    input  logic          line_sync,
    input  logic          pause_cpu,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    input  logic [7:0]    VD_in,
    output logic [AW-1:0] VA,
    output logic [7:0]    VD_out,
    output logic          V_C,
    output logic          VWE_n,
    output logic          VOE_n,
    output logic [1:0]    phase,
    output logic          grant_id
);

    // The whole access (setup + strobe + hold) must fit inside the CPU
    // phase, so the sequencer never needs to abort when the phase moves on.
    if (STROBE_LEN < 1 || STROBE_LEN > 6 || (2 + STROBE_LEN) > CEN_PERIOD ||
        AW < 1 || AW > VBUS_ADDR_MAX) begin : g_paramCheck
        $error("athena_vbus_arbiter: illegal AW/STROBE_LEN/CEN_PERIOD");
    end

    localparam logic [2:0] STROBE_LAST = 3'(STROBE_LEN - 1);

    vbus_state_t   state_q, state_d;
    logic [2:0]    strobeCnt_q, strobeCnt_d;
    logic [1:0]    phase_q, phase_d;
    logic          syncPending_q, syncPending_d;
    logic          syncNow;
    logic          enterCpuPhase;
    logic          arbEn;
    logic          grantFire;
    logic [1:0]    gntOnehot;
    logic          gntId;
    vbus_req_t     aReqBus, bReqBus;
    vbus_req_t     req_q, req_d;
    logic          grantId_q, grantId_d;
    logic          busOwned;
    logic          vc_q, vc_d;
    logic [AW-1:0] va_q, va_d;
    logic [7:0]    vdOut_q, vdOut_d;
    logic          vweN_q, vweN_d;
    logic          voeN_q, voeN_d;
    logic          aAck_q, aAck_d;
    logic          bAck_q, bAck_d;
    logic [7:0]    aRdata_q, aRdata_d;
    logic [7:0]    bRdata_q, bRdata_d;
    logic          unusedAddrBits;

    // Phase counter. A line_sync seen between phase_cen pulses is remembered
    // until the next pulse; one arriving together with phase_cen acts at once.
    always_comb begin
        syncNow       = line_sync | syncPending_q;
        phase_d       = phase_q;
        syncPending_d = syncPending_q | line_sync;
        if (phase_cen) begin
            phase_d       = nextPhase(phase_q, syncNow);
            syncPending_d = 1'b0;
        end
    end

    // Arbitration is only allowed on the edge that really enters the CPU
    // phase (a sync-forced restart to 0 from phase 2 does not count).
    assign enterCpuPhase = phase_cen && !syncNow &&
                           (phase_q == CPU_PHASE - 2'd1);
    assign arbEn         = enterCpuPhase && (state_q == IDLE) && !pause_cpu;
    assign grantFire     = |gntOnehot;

    athena_rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        ({b_req, a_req}),
        .arb_en     (arbEn),
        .gnt_onehot (gntOnehot),
        .gnt_id     (gntId)
    );

    // Bundle each requester's fields so the winner can be captured whole.
    always_comb begin
        aReqBus.we    = a_we;
        aReqBus.addr  = VBUS_ADDR_MAX'(a_addr);
        aReqBus.wdata = a_wdata;
        bReqBus.we    = b_we;
        bReqBus.addr  = VBUS_ADDR_MAX'(b_addr);
        bReqBus.wdata = b_wdata;
    end

    // Access sequencer: SETUP for one clk, STROBE for STROBE_LEN clks, HOLD
    // for one clk, then back to IDLE. The request is frozen at the grant so
    // the requester may drop its inputs afterwards without disturbing the bus.
    always_comb begin
        state_d     = state_q;
        strobeCnt_d = strobeCnt_q;
        req_d       = req_q;
        grantId_d   = grantId_q;
        case (state_q)
            IDLE: begin
                if (grantFire) begin
                    state_d   = SETUP;
                    req_d     = gntId ? bReqBus : aReqBus;
                    grantId_d = gntId;
                end
            end
            SETUP: begin
                state_d     = STROBE;
                strobeCnt_d = 3'd0;
            end
            STROBE: begin
                if (strobeCnt_q == STROBE_LAST) begin
                    state_d = HOLD;
                end else begin
                    strobeCnt_d = strobeCnt_q + 3'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        busOwned = (state_d != IDLE);
        vc_d     = busOwned;
        va_d     = busOwned ? req_d.addr[AW-1:0] : '0;
        vdOut_d  = (busOwned && req_d.we) ? req_d.wdata : 8'hFF;
        vweN_d   = !((state_d == STROBE) && req_d.we);
        voeN_d   = !((state_d == STROBE) && !req_d.we);
        aAck_d   = (state_d == HOLD) && !grantId_d;
        bAck_d   = (state_d == HOLD) && grantId_d;
        aRdata_d = aRdata_q;
        bRdata_d = bRdata_q;
        // Read data is taken during the last strobe clk, while VOE_n is
        // still low, and is kept until that requester's next read.
        if ((state_q == STROBE) && (state_d == HOLD) && !req_q.we) begin
            if (grantId_q) begin
                bRdata_d = VD_in;
            end else begin
                aRdata_d = VD_in;
            end
        end
    end

    // Address bits above AW only exist because the bundle is sized for the
    // widest supported bus.
    assign unusedAddrBits = ^req_d.addr;

    // All state and outputs. Reset drops an in-flight access immediately,
    // without an acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            strobeCnt_q   <= 3'd0;
            phase_q       <= 2'd0;
            syncPending_q <= 1'b0;
            req_q         <= '0;
            grantId_q     <= 1'b0;
            vc_q          <= 1'b0;
            va_q          <= '0;
            vdOut_q       <= 8'hFF;
            vweN_q        <= 1'b1;
            voeN_q        <= 1'b1;
            aAck_q        <= 1'b0;
            bAck_q        <= 1'b0;
            aRdata_q      <= 8'h00;
            bRdata_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            strobeCnt_q   <= strobeCnt_d;
            phase_q       <= phase_d;
            syncPending_q <= syncPending_d;
            req_q         <= req_d;
            grantId_q     <= grantId_d;
            vc_q          <= vc_d;
            va_q          <= va_d;
            vdOut_q       <= vdOut_d;
            vweN_q        <= vweN_d;
            voeN_q        <= voeN_d;
            aAck_q        <= aAck_d;
            bAck_q        <= bAck_d;
            aRdata_q      <= aRdata_d;
            bRdata_q      <= bRdata_d;
        end
    end

    assign phase    = phase_q;
    assign V_C      = vc_q;
    assign VA       = va_q;
    assign VD_out   = vdOut_q;
    assign VWE_n    = vweN_q;
    assign VOE_n    = voeN_q;
    assign a_ack    = aAck_q;
    assign b_ack    = bAck_q;
    assign a_rdata  = aRdata_q;
    assign b_rdata  = bRdata_q;
    assign grant_id = grantId_q;

endmodule

// File: tb/tb_athena_vbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_athena_vbus_arbiter
// Directed bench for athena_vbus_arbiter at default parameters
// (AW=13, STROBE_LEN=4, CEN_PERIOD=8). phase_cen is a free-running pulse
// every 8 clks. Outputs are sampled 1 ns after the rising edge.
// Access timeline seen from the first sample with V_C=1 (index 1):
//   1 SETUP, 2..5 STROBE, 6 HOLD (ack), 7 IDLE.
// ---------------------------------------------------------------------------
module tb_athena_vbus_arbiter;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          phase_cen = 1'b0;
    logic          line_sync = 1'b0;
    logic          pause_cpu = 1'b0;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [7:0]    a_rdata, b_rdata;
    logic [7:0]    VD_in = 8'h00;
    logic [AW-1:0] VA;
    logic [7:0]    VD_out;
    logic          V_C, VWE_n, VOE_n, grant_id;
    logic [1:0]    phase;

    int vectors = 0;
    int miscompares = 0;
    int cenCnt = 0;

    // Trace results of one access
    int         trVc, trWe, trOe, trAckA, trAckB, trAckAIdx, trAckBIdx;
    int         trVdOk, trVaOk;
    logic [1:0] trPhase;
    logic       trGid;

    athena_vbus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .phase_cen (phase_cen),
        .line_sync (line_sync),
        .pause_cpu (pause_cpu),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .VD_in     (VD_in),
        .VA        (VA),
        .VD_out    (VD_out),
        .V_C       (V_C),
        .VWE_n     (VWE_n),
        .VOE_n     (VOE_n),
        .phase     (phase),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Pixel-enable pulse: one clk out of every eight
    always @(negedge clk) begin
        cenCnt    = (cenCnt + 1) % 8;
        phase_cen = (cenCnt == 0);
    end

    // Hard stop in case something unforeseen stalls the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic aReq, input logic aWe,
                                 input logic [AW-1:0] aAddr, input logic [7:0] aWdata,
                                 input logic bReq, input logic bWe,
                                 input logic [AW-1:0] bAddr, input logic [7:0] bWdata);
        a_req   = aReq;
        a_we    = aWe;
        a_addr  = aAddr;
        a_wdata = aWdata;
        b_req   = bReq;
        b_we    = bWe;
        b_addr  = bAddr;
        b_wdata = bWdata;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic waitVc(input int limit, output int steps);
        steps = 0;
        while (V_C !== 1'b1 && steps < limit) begin
            stepClk();
            steps++;
        end
    endtask

    // Record 7 samples starting at the SETUP sample
    task automatic traceAccess(input logic [7:0] expVd, input logic [AW-1:0] expVa);
        trVc = 0; trWe = 0; trOe = 0; trAckA = 0; trAckB = 0;
        trAckAIdx = 0; trAckBIdx = 0; trVdOk = 0; trVaOk = 0;
        trPhase = phase;
        trGid   = grant_id;
        for (int i = 1; i <= 7; i++) begin
            if (V_C === 1'b1) trVc++;
            if (VWE_n === 1'b0) trWe++;
            if (VOE_n === 1'b0) trOe++;
            if (a_ack === 1'b1) begin
                trAckA++;
                if (trAckAIdx == 0) trAckAIdx = i;
            end
            if (b_ack === 1'b1) begin
                trAckB++;
                if (trAckBIdx == 0) trAckBIdx = i;
            end
            if (V_C === 1'b1 && VD_out === expVd) trVdOk++;
            if (V_C === 1'b1 && VA === expVa) trVaOk++;
            if (i < 7) stepClk();
        end
    endtask

    initial begin
        int steps;
        int vcSeen;
        int ackSeen;
        int p3Idle;
        logic expGid [4];

        // ---------------- reset values ----------------
        applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
        reset = 1'b1;
        repeat (3) stepClk();
        checkOutput("rst_phase", phase, 2'd0);
        checkOutput("rst_vc", V_C, 1'b0);
        checkOutput("rst_va", VA, 13'h0000);
        checkOutput("rst_vd_out", VD_out, 8'hFF);
        checkOutput("rst_vwe_n", VWE_n, 1'b1);
        checkOutput("rst_voe_n", VOE_n, 1'b1);
        checkOutput("rst_a_ack", a_ack, 1'b0);
        checkOutput("rst_b_ack", b_ack, 1'b0);
        checkOutput("rst_a_rdata", a_rdata, 8'h00);
        checkOutput("rst_b_rdata", b_rdata, 8'h00);
        checkOutput("rst_grant_id", grant_id, 1'b0);
        reset = 1'b0;

        // ---------------- A read ----------------
        applyStimulus(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0, 1'b0, '0, 8'h00);
        VD_in = 8'h5A;
        waitVc(64, steps);
        checkOutput("rd_vc_seen", V_C, 1'b1);
        traceAccess(8'hFF, 13'h0123);
        checkOutput("rd_phase", trPhase, 2'd3);
        checkOutput("rd_gid", trGid, 1'b0);
        checkOutput("rd_vc_cycles", trVc, 6);
        checkOutput("rd_va_cycles", trVaOk, 6);
        checkOutput("rd_vd_ff_cycles", trVdOk, 6);
        checkOutput("rd_oe_low", trOe, 4);
        checkOutput("rd_we_low", trWe, 0);
        checkOutput("rd_ack_idx", trAckAIdx, 6);
        checkOutput("rd_ack_count", trAckA, 1);
        checkOutput("rd_b_ack_count", trAckB, 0);
        checkOutput("rd_idle_vc", V_C, 1'b0);
        checkOutput("rd_idle_va", VA, 13'h0000);
        checkOutput("rd_a_rdata", a_rdata, 8'h5A);
        a_req = 1'b0;

        // ---------------- B write ----------------
        applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1, 13'h1FFF, 8'hC3);
        VD_in = 8'h99;
        waitVc(64, steps);
        checkOutput("wr_vc_seen", V_C, 1'b1);
        traceAccess(8'hC3, 13'h1FFF);
        checkOutput("wr_phase", trPhase, 2'd3);
        checkOutput("wr_gid", trGid, 1'b1);
        checkOutput("wr_vd_cycles", trVdOk, 6);
        checkOutput("wr_va_cycles", trVaOk, 6);
        checkOutput("wr_we_low", trWe, 4);
        checkOutput("wr_oe_low", trOe, 0);
        checkOutput("wr_ack_idx", trAckBIdx, 6);
        checkOutput("wr_ack_count", trAckB, 1);
        checkOutput("wr_a_ack_count", trAckA, 0);
        checkOutput("wr_idle_vd_out", VD_out, 8'hFF);
        checkOutput("wr_b_rdata", b_rdata, 8'h00);
        checkOutput("wr_a_rdata", a_rdata, 8'h5A);
        b_req = 1'b0;

        // ---------------- both requesting: A,B,A,B ----------------
        reset = 1'b1;
        stepClk();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 13'h0AAA, 8'h00, 1'b1, 1'b1, 13'h0BBB, 8'h3C);
        VD_in = 8'h11;
        expGid[0] = 1'b0; expGid[1] = 1'b1; expGid[2] = 1'b0; expGid[3] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            waitVc(64, steps);
            checkOutput($sformatf("rr%0d_vc_seen", w), V_C, 1'b1);
            if (expGid[w]) traceAccess(8'h3C, 13'h0BBB);
            else           traceAccess(8'hFF, 13'h0AAA);
            checkOutput($sformatf("rr%0d_gid", w), trGid, expGid[w]);
            checkOutput($sformatf("rr%0d_va_cycles", w), trVaOk, 6);
            checkOutput($sformatf("rr%0d_a_acks", w), trAckA, expGid[w] ? 0 : 1);
            checkOutput($sformatf("rr%0d_b_acks", w), trAckB, expGid[w] ? 1 : 0);
        end
        checkOutput("rr_a_rdata", a_rdata, 8'h11);
        checkOutput("rr_b_rdata", b_rdata, 8'h00);
        a_req = 1'b0;
        b_req = 1'b0;

        // ---------------- pause_cpu for 3 windows ----------------
        pause_cpu = 1'b1;
        applyStimulus(1'b1, 1'b0, 13'h0444, 8'h00, 1'b0, 1'b0, '0, 8'h00);
        VD_in = 8'h22;
        vcSeen = 0;
        ackSeen = 0;
        for (int i = 0; i < 96; i++) begin
            stepClk();
            if (V_C !== 1'b0) vcSeen++;
            if (a_ack !== 1'b0) ackSeen++;
        end
        checkOutput("pause_vc_cycles", vcSeen, 0);
        checkOutput("pause_ack_cycles", ackSeen, 0);
        steps = 0;
        while (phase !== 2'd1 && steps < 40) begin
            stepClk();
            steps++;
        end
        checkOutput("pause_reach_phase1", phase, 2'd1);
        pause_cpu = 1'b0;
        steps = 0;
        p3Idle = 0;
        while (V_C !== 1'b1 && steps < 40) begin
            if (phase === 2'd3) p3Idle++;
            stepClk();
            steps++;
        end
        checkOutput("unpause_vc_seen", V_C, 1'b1);
        checkOutput("unpause_missed_phase3", p3Idle, 0);
        traceAccess(8'hFF, 13'h0444);
        checkOutput("unpause_phase", trPhase, 2'd3);
        checkOutput("unpause_ack_count", trAckA, 1);
        checkOutput("unpause_a_rdata", a_rdata, 8'h22);
        a_req = 1'b0;

        // ---------------- reset during STROBE ----------------
        applyStimulus(1'b1, 1'b1, 13'h0555, 8'h77, 1'b0, 1'b0, '0, 8'h00);
        waitVc(64, steps);
        checkOutput("mid_vc_seen", V_C, 1'b1);
        stepClk();
        stepClk();
        checkOutput("mid_strobe_vwe_n", VWE_n, 1'b0);
        checkOutput("mid_strobe_vd_out", VD_out, 8'h77);
        reset = 1'b1;
        stepClk();
        checkOutput("mid_rst_vwe_n", VWE_n, 1'b1);
        checkOutput("mid_rst_voe_n", VOE_n, 1'b1);
        checkOutput("mid_rst_vc", V_C, 1'b0);
        checkOutput("mid_rst_vd_out", VD_out, 8'hFF);
        checkOutput("mid_rst_va", VA, 13'h0000);
        checkOutput("mid_rst_phase", phase, 2'd0);
        checkOutput("mid_rst_a_ack", a_ack, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);
        ackSeen = 0;
        for (int i = 0; i < 10; i++) begin
            stepClk();
            if (a_ack !== 1'b0) ackSeen++;
        end
        checkOutput("mid_rst_no_late_ack", ackSeen, 0);
        applyStimulus(1'b1, 1'b0, 13'h0666, 8'h00, 1'b1, 1'b0, 13'h0777, 8'h00);
        waitVc(64, steps);
        checkOutput("post_rst_vc_seen", V_C, 1'b1);
        checkOutput("post_rst_gid", grant_id, 1'b0);
        traceAccess(8'hFF, 13'h0666);
        checkOutput("post_rst_ack_idx", trAckAIdx, 6);
        applyStimulus(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00);

        // ---------------- line_sync in phase 1 ----------------
        steps = 0;
        while (phase !== 2'd1 && steps < 40) begin
            stepClk();
            steps++;
        end
        checkOutput("sync_reach_phase1", phase, 2'd1);
        line_sync = 1'b1;
        stepClk();
        line_sync = 1'b0;
        steps = 0;
        while (phase === 2'd1 && steps < 16) begin
            stepClk();
            steps++;
        end
        checkOutput("sync_phase_zero", phase, 2'd0);
        applyStimulus(1'b1, 1'b0, 13'h0888, 8'h00, 1'b0, 1'b0, '0, 8'h00);
        waitVc(64, steps);
        checkOutput("sync_vc_seen", V_C, 1'b1);
        checkOutput("sync_window_delay", steps, 24);
        traceAccess(8'hFF, 13'h0888);
        checkOutput("sync_phase", trPhase, 2'd3);
        checkOutput("sync_ack_count", trAckA, 1);
        a_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
